// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the in-order write-back stage
// and a small FIFO of multiply/divide results, with a drain mode against starvation.
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int RAW        = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         pipe_valid_i,
    input  logic                         pipe_we_i,
    input  logic [RAW-1:0]               pipe_rd_i,
    input  logic [XLEN-1:0]              pipe_data_i,
    output logic                         pipe_stall_o,
    input  logic                         mdu_valid_i,
    input  logic [RAW-1:0]               mdu_rd_i,
    input  logic [XLEN-1:0]              mdu_data_i,
    output logic                         mdu_ready_o,
    output logic                         rf_we_o,
    output logic [RAW-1:0]               rf_rd_o,
    output logic [XLEN-1:0]              rf_wd_o,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {S_NORMAL, S_DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic [RAW-1:0]  r_mem_rd [DEPTH];
    logic [XLEN-1:0] r_mem_wd [DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [SW-1:0]   r_starve, w_starve_nxt;
    logic            r_rf_we;
    logic [RAW-1:0]  r_rf_rd;
    logic [XLEN-1:0] r_rf_wd;
    logic            w_pipe_req, w_fifo_req, w_grant_pipe, w_grant_fifo, w_push, w_starve_hit;

    assign w_pipe_req   = pipe_valid_i & pipe_we_i;
    assign w_fifo_req   = (r_count != '0);
    assign mdu_ready_o  = (r_count != CW'(DEPTH)) & ~rst_i;
    assign w_push       = mdu_valid_i & mdu_ready_o;
    assign rf_we_o      = r_rf_we;
    assign rf_rd_o      = r_rf_rd;
    assign rf_wd_o      = r_rf_wd;
    assign fifo_count_o = r_count;

    always_comb begin
        w_grant_pipe = 1'b0;
        w_grant_fifo = 1'b0;
        pipe_stall_o = 1'b0;
        w_state_nxt  = r_state;
        case (r_state)
            S_NORMAL: begin
                w_grant_pipe = w_pipe_req;
                w_grant_fifo = ~w_pipe_req & w_fifo_req;
            end
            default: begin
                w_grant_fifo = w_fifo_req;
                pipe_stall_o = w_pipe_req & ~rst_i;
            end
        endcase

        w_count_nxt  = r_count + CW'(w_push) - CW'(w_grant_fifo);
        w_starve_nxt = (w_fifo_req & ~w_grant_fifo) ? r_starve + SW'(1) : '0;
        // Never exceeds STARVE_MAX: reaching it forces DRAIN, which grants the FIFO.
        w_starve_hit = (w_starve_nxt == SW'(STARVE_MAX));

        case (r_state)
            S_NORMAL: if (w_starve_hit || w_count_nxt == CW'(DEPTH)) w_state_nxt = S_DRAIN;
            default:  if (w_count_nxt == '0) w_state_nxt = S_NORMAL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_NORMAL;
            r_count  <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_starve <= '0;
            r_rf_we  <= 1'b0;
            r_rf_rd  <= '0;
            r_rf_wd  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_starve <= w_starve_nxt;
            if (w_push) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            if (w_grant_fifo) r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);

            // x0 writes still consume the grant but never reach the register file
            r_rf_we <= 1'b0;
            if (w_grant_pipe) begin
                r_rf_we <= (pipe_rd_i != '0);
                r_rf_rd <= pipe_rd_i;
                r_rf_wd <= pipe_data_i;
            end else if (w_grant_fifo) begin
                r_rf_we <= (r_mem_rd[r_rptr] != '0);
                r_rf_rd <= r_mem_rd[r_rptr];
                r_rf_wd <= r_mem_wd[r_rptr];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_rd[r_wptr] <= mdu_rd_i;
            r_mem_wd[r_wptr] <= mdu_data_i;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based model of the
// write-port arbitration rules.
module tb_wb_port_arbiter;

    localparam int XLEN = 32, RAW = 5, DEPTH = 2, STARVE_MAX = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            pipe_valid_i, pipe_we_i, mdu_valid_i;
    logic [RAW-1:0]  pipe_rd_i, mdu_rd_i;
    logic [XLEN-1:0] pipe_data_i, mdu_data_i;
    logic            pipe_stall_o, mdu_ready_o, rf_we_o;
    logic [RAW-1:0]  rf_rd_o;
    logic [XLEN-1:0] rf_wd_o;
    logic [1:0]      fifo_count_o;

    wb_port_arbiter #(.XLEN(XLEN), .RAW(RAW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pipe_valid_i(pipe_valid_i), .pipe_we_i(pipe_we_i), .pipe_rd_i(pipe_rd_i),
        .pipe_data_i(pipe_data_i), .pipe_stall_o(pipe_stall_o),
        .mdu_valid_i(mdu_valid_i), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
        .mdu_ready_o(mdu_ready_o),
        .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_wd_o(rf_wd_o), .fifo_count_o(fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [RAW-1:0] rd; logic [XLEN-1:0] d; } ent_t;

    ent_t            mq[$];
    bit              m_drain;
    int              m_starve;
    logic            e_we;
    logic [RAW-1:0]  e_rd;
    logic [XLEN-1:0] e_wd;
    int              n_tests = 0, n_fail = 0;

    // Advance the model by one cycle from the current inputs, then clock the DUT.
    task automatic tick();
        bit gp, gf, push, nonempty;
        if (rst_i) begin
            mq.delete(); m_drain = 0; m_starve = 0; e_we = 0; e_rd = '0; e_wd = '0;
        end else begin
            nonempty = (mq.size() > 0);
            gp = 0; gf = 0;
            if (m_drain) gf = nonempty;
            else if (pipe_valid_i && pipe_we_i) gp = 1;
            else gf = nonempty;
            push = mdu_valid_i && (mq.size() < DEPTH);
            e_we = 0;
            if (gp) begin e_we = (pipe_rd_i != 0); e_rd = pipe_rd_i; e_wd = pipe_data_i; end
            if (gf) begin e_we = (mq[0].rd != 0); e_rd = mq[0].rd; e_wd = mq[0].d; void'(mq.pop_front()); end
            if (push) mq.push_back('{mdu_rd_i, mdu_data_i});
            m_starve = (nonempty && !gf) ? m_starve + 1 : 0;
            if (!m_drain && (m_starve >= STARVE_MAX || mq.size() == DEPTH)) m_drain = 1;
            else if (m_drain && mq.size() == 0) m_drain = 0;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic idle();
        pipe_valid_i = 0; pipe_we_i = 0; pipe_rd_i = '0; pipe_data_i = '0;
        mdu_valid_i = 0; mdu_rd_i = '0; mdu_data_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1; idle(); tick(); rst_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; idle(); pipe_valid_i = 1; pipe_we_i = 1; mdu_valid_i = 1; #1;
        n_tests++; if (mdu_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", mdu_ready_o); end
        n_tests++; if (pipe_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", pipe_stall_o); end
        tick(); tick(); idle(); rst_i = 0; #1;
        n_tests++; if ({rf_we_o, rf_rd_o, rf_wd_o} !== '0) begin n_fail++; $display("FAIL reset_rf got=%b/%0d/%h exp=0/0/0", rf_we_o, rf_rd_o, rf_wd_o); end
        n_tests++; if (fifo_count_o !== 2'd0 || mdu_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_fifo got cnt=%0d rdy=%b exp 0/1", fifo_count_o, mdu_ready_o); end
    endtask

    task automatic test_pipe_alone();
        do_reset();
        pipe_valid_i = 1; pipe_we_i = 1; pipe_rd_i = 5; pipe_data_i = 32'hDEADBEEF; #1;
        n_tests++; if (pipe_stall_o !== 1'b0) begin n_fail++; $display("FAIL pipe_stall got=%b exp=0", pipe_stall_o); end
        tick(); idle();
        n_tests++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd5 || rf_wd_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pipe_write got=%b/%0d/%h exp=1/5/deadbeef", rf_we_o, rf_rd_o, rf_wd_o); end
        pipe_valid_i = 1; pipe_we_i = 0; pipe_rd_i = 9; tick(); idle();
        n_tests++; if (rf_we_o !== 1'b0 || rf_rd_o !== 5'd5 || rf_wd_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pipe_hold got=%b/%0d/%h exp=0/5/deadbeef", rf_we_o, rf_rd_o, rf_wd_o); end
    endtask

    task automatic test_mdu_alone();
        do_reset();
        mdu_valid_i = 1; mdu_rd_i = 7; mdu_data_i = 42; tick(); idle();
        n_tests++; if (rf_we_o !== 1'b0 || fifo_count_o !== 2'd1) begin n_fail++; $display("FAIL mdu_push got we=%b cnt=%0d exp 0/1", rf_we_o, fifo_count_o); end
        tick();
        n_tests++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd7 || rf_wd_o !== 32'd42 || fifo_count_o !== 2'd0) begin n_fail++; $display("FAIL mdu_write got=%b/%0d/%0d cnt=%0d exp=1/7/42 cnt=0", rf_we_o, rf_rd_o, rf_wd_o, fifo_count_o); end
    endtask

    task automatic test_starvation();
        do_reset();
        pipe_valid_i = 1; pipe_we_i = 1; pipe_rd_i = 3; pipe_data_i = 32'h33;
        mdu_valid_i = 1; mdu_rd_i = 9; mdu_data_i = 32'h99; tick(); mdu_valid_i = 0;
        for (int i = 0; i < STARVE_MAX; i++) begin
            n_tests++; if (pipe_stall_o !== 1'b0) begin n_fail++; $display("FAIL starve_wait%0d stall=%b exp=0", i, pipe_stall_o); end
            tick();
            n_tests++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd3) begin n_fail++; $display("FAIL starve_pipe%0d got=%b/%0d exp=1/3", i, rf_we_o, rf_rd_o); end
        end
        n_tests++; if (pipe_stall_o !== 1'b1) begin n_fail++; $display("FAIL starve_drain stall=%b exp=1", pipe_stall_o); end
        tick();
        n_tests++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd9 || rf_wd_o !== 32'h99) begin n_fail++; $display("FAIL starve_mdu got=%b/%0d/%h exp=1/9/99", rf_we_o, rf_rd_o, rf_wd_o); end
        n_tests++; if (pipe_stall_o !== 1'b0 || fifo_count_o !== 2'd0) begin n_fail++; $display("FAIL starve_resume stall=%b cnt=%0d exp 0/0", pipe_stall_o, fifo_count_o); end
        idle(); tick();
    endtask

    task automatic fill_under_pipe();
        pipe_valid_i = 1; pipe_we_i = 1; pipe_rd_i = 4; pipe_data_i = 32'h44;
        mdu_valid_i = 1; mdu_rd_i = 10; mdu_data_i = 32'hA; tick();
        mdu_rd_i = 11; mdu_data_i = 32'hB; tick(); mdu_valid_i = 0;
    endtask

    task automatic test_full();
        do_reset(); fill_under_pipe();
        n_tests++; if (mdu_ready_o !== 1'b0 || fifo_count_o !== 2'd2 || pipe_stall_o !== 1'b1) begin n_fail++; $display("FAIL full_state rdy=%b cnt=%0d stall=%b exp 0/2/1", mdu_ready_o, fifo_count_o, pipe_stall_o); end
        tick();
        n_tests++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd10 || rf_wd_o !== 32'hA) begin n_fail++; $display("FAIL full_first got=%b/%0d/%h exp=1/10/a", rf_we_o, rf_rd_o, rf_wd_o); end
        n_tests++; if (pipe_stall_o !== 1'b1) begin n_fail++; $display("FAIL full_stall2 stall=%b exp=1", pipe_stall_o); end
        tick();
        n_tests++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd11 || rf_wd_o !== 32'hB) begin n_fail++; $display("FAIL full_second got=%b/%0d/%h exp=1/11/b", rf_we_o, rf_rd_o, rf_wd_o); end
        n_tests++; if (pipe_stall_o !== 1'b0 || fifo_count_o !== 2'd0 || mdu_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_resume stall=%b cnt=%0d rdy=%b exp 0/0/1", pipe_stall_o, fifo_count_o, mdu_ready_o); end
        idle(); tick();
    endtask

    task automatic test_x0();
        do_reset();
        mdu_valid_i = 1; mdu_rd_i = 0; mdu_data_i = 32'h55; tick(); idle();
        n_tests++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL x0_push we=%b exp=0", rf_we_o); end
        tick();
        n_tests++; if (rf_we_o !== 1'b0 || fifo_count_o !== 2'd0) begin n_fail++; $display("FAIL x0_mdu we=%b cnt=%0d exp 0/0", rf_we_o, fifo_count_o); end
        pipe_valid_i = 1; pipe_we_i = 1; pipe_rd_i = 0; pipe_data_i = 32'h66; tick(); idle();
        n_tests++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL x0_pipe we=%b exp=0", rf_we_o); end
    endtask

    task automatic test_reset_in_drain();
        do_reset(); fill_under_pipe();
        rst_i = 1; #1;
        n_tests++; if (mdu_ready_o !== 1'b0 || pipe_stall_o !== 1'b0) begin n_fail++; $display("FAIL rstdrain_during rdy=%b stall=%b exp 0/0", mdu_ready_o, pipe_stall_o); end
        tick(); rst_i = 0; idle(); #1;
        n_tests++; if (fifo_count_o !== 2'd0 || rf_we_o !== 1'b0 || mdu_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstdrain_after cnt=%0d we=%b rdy=%b exp 0/0/1", fifo_count_o, rf_we_o, mdu_ready_o); end
        pipe_valid_i = 1; pipe_we_i = 1; pipe_rd_i = 12; pipe_data_i = 32'hC; #1;
        n_tests++; if (pipe_stall_o !== 1'b0) begin n_fail++; $display("FAIL rstdrain_normal stall=%b exp=0", pipe_stall_o); end
        tick(); idle();
        n_tests++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd12) begin n_fail++; $display("FAIL rstdrain_pipe got=%b/%0d exp=1/12", rf_we_o, rf_rd_o); end
    endtask

    task automatic test_random();
        bit preq;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_i        = ($urandom_range(0, 99) == 0);
            pipe_valid_i = ($urandom_range(0, 9) < 7);
            pipe_we_i    = ($urandom_range(0, 9) < 8);
            pipe_rd_i    = ($urandom_range(0, 7) == 0) ? '0 : RAW'($urandom);
            pipe_data_i  = $urandom;
            mdu_valid_i  = ($urandom_range(0, 9) < 4);
            mdu_rd_i     = ($urandom_range(0, 7) == 0) ? '0 : RAW'($urandom);
            mdu_data_i   = $urandom;
            #1;
            preq = pipe_valid_i && pipe_we_i;
            n_tests++;
            if (pipe_stall_o !== (!rst_i && m_drain && preq) || mdu_ready_o !== (!rst_i && mq.size() < DEPTH) || fifo_count_o !== 2'(mq.size())) begin
                n_fail++; $display("FAIL rand_comb c=%0d stall=%b rdy=%b cnt=%0d exp %b/%b/%0d", c, pipe_stall_o, mdu_ready_o, fifo_count_o, !rst_i && m_drain && preq, !rst_i && mq.size() < DEPTH, mq.size());
            end
            tick();
            n_tests++;
            if (rf_we_o !== e_we || (e_we && (rf_rd_o !== e_rd || rf_wd_o !== e_wd))) begin
                n_fail++; $display("FAIL rand_rf c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rf_we_o, rf_rd_o, rf_wd_o, e_we, e_rd, e_wd);
            end
        end
        rst_i = 0; idle();
    endtask

    initial begin
        m_drain = 0; m_starve = 0; e_we = 0; e_rd = '0; e_wd = '0;
        rst_i = 1; idle();
        test_reset();
        test_pipe_alone();
        test_mdu_alone();
        test_starvation();
        test_full();
        test_x0();
        test_reset_in_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
